mem_arbiter: RTL and testbench

- Two-port arbiter/sequencer in front of the byte-addressed, big-endian, 32-bit-word data memory (active-low write strobe, writes on clock falling edge, combinational read).
- Port 0 is the CPU load/store path: single word per request.
- Port 1 is a burst engine, e.g. a sprite/tile fetcher: N consecutive words at +4-byte strides.
- Serialises both ports onto the memory's single address/data/write interface; only this block drives the memory.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_burst_cnt.sv | 63 ++++++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    BURST
  } arb_state_e;

  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_BURST = 1'b1;

  localparam int unsigned BEAT_BYTES = 4;

endpackage

// File: rtl/mem_arb_burst_cnt.sv
// Burst beat counter for port 1: latches base and clamped length at start,
// produces the beat address (base + 4*i, wrapping) and a last-beat flag.
module mem_arb_burst_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [31:0]      base_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             advance_i,
  output logic [31:0]      addr_o,
  output logic             last_o
);

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] last_idx_q, last_idx_d;
  logic [31:0]      base_q, base_d;
  logic [LEN_W-1:0] len_eff;

  always_comb begin
    if (len_i == '0) begin
      len_eff = LEN_W'(1);
    end else if (len_i > LEN_W'(MAX_BURST)) begin
      len_eff = LEN_W'(MAX_BURST);
    end else begin
      len_eff = len_i;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    base_d     = base_q;
    if (start_i) begin
      cnt_d      = '0;
      last_idx_d = len_eff - LEN_W'(1);
      base_d     = base_i;
    end else if (advance_i) begin
      cnt_d = cnt_q + LEN_W'(1);
    end
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      last_idx_q <= '0;
      base_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      base_q     <= base_d;
    end
  end

  assign addr_o = base_q + (32'(cnt_q) * 32'(BEAT_BYTES));
  assign last_o = (cnt_q == last_idx_q);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises a CPU single-word port and a burst-fetch port onto one memory.
// Define MEM_ARB_RR_EN for round-robin on ties; otherwise port 0 always wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_ack,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [31:0]      m1_addr,
  input  logic [LEN_W-1:0] m1_len,
  input  logic [31:0]      m1_wdata,
  output logic             m1_wnext,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,
  output logic             m1_done,
  output logic             mem_wr_n,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout
);

  arb_state_e  state_q, state_d;
  logic        m0_ack_q, m0_ack_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic        m1_rvalid_q, m1_rvalid_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        m1_done_q, m1_done_d;

  logic        m0_cand, m1_cand;
  logic        grant_m0, grant_m1;
  logic        burst_start, burst_adv, burst_last;
  logic [31:0] burst_addr;

  mem_arb_burst_cnt #(
    .MAX_BURST (MAX_BURST),
    .LEN_W     (LEN_W)
  ) u_burst_cnt (
    .clk       (clk),
    .rst       (rst),
    .start_i   (burst_start),
    .base_i    (m1_addr),
    .len_i     (m1_len),
    .advance_i (burst_adv),
    .addr_o    (burst_addr),
    .last_o    (burst_last)
  );

  // A requester still holding req during its own ack/done cycle is not re-granted.
  assign m0_cand = m0_req & ~m0_ack_q;
  assign m1_cand = m1_req & ~m1_done_q;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;

  assign grant_m0 = m0_cand & (~m1_cand | (last_grant_q != PORT_CPU));
  assign grant_m1 = m1_cand & ~grant_m0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= PORT_BURST;
    end else if (state_q == IDLE) begin
      if (grant_m0) begin
        last_grant_q <= PORT_CPU;
      end else if (grant_m1) begin
        last_grant_q <= PORT_BURST;
      end
    end
  end
`else
  assign grant_m0 = m0_cand;
  assign grant_m1 = m1_cand & ~m0_cand;
`endif

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    m0_ack_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rvalid_d = 1'b0;
    m1_rdata_d  = m1_rdata_q;
    m1_done_d   = 1'b0;
    burst_start = 1'b0;
    burst_adv   = 1'b0;
    m1_wnext    = 1'b0;
    mem_wr_n    = 1'b1;
    mem_addr    = '0;
    mem_din     = '0;

    case (state_q)
      IDLE: begin
        if (grant_m0) begin
          state_d = SINGLE;
        end else if (grant_m1) begin
          state_d     = BURST;
          burst_start = 1'b1;
        end
      end

      SINGLE: begin
        mem_addr   = m0_addr;
        mem_din    = m0_wdata;
        mem_wr_n   = ~m0_we;
        m0_rdata_d = mem_dout;
        m0_ack_d   = 1'b1;
        state_d    = IDLE;
      end

      BURST: begin
        mem_addr  = burst_addr;
        mem_din   = m1_wdata;
        mem_wr_n  = ~m1_we;
        m1_wnext  = m1_we;
        burst_adv = 1'b1;
        if (!m1_we) begin
          m1_rvalid_d = 1'b1;
          m1_rdata_d  = mem_dout;
        end
        if (burst_last) begin
          m1_done_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      m0_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rvalid_q <= 1'b0;
      m1_rdata_q  <= '0;
      m1_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      m0_ack_q    <= m0_ack_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rvalid_q <= m1_rvalid_d;
      m1_rdata_q  <= m1_rdata_d;
      m1_done_q   <= m1_done_d;
    end
  end

  assign m0_ack    = m0_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m1_rdata  = m1_rdata_q;
  assign m1_done   = m1_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter with a byte-level big-endian memory model
// and a transaction-level reference model (grant order, latency, data).
module tb_mem_arbiter;

  localparam int MAX_BURST = 16;
  localparam int LEN_W     = $clog2(MAX_BURST + 1);

  logic             clk;
  logic             rst;
  logic             m0_req, m0_we;
  logic [31:0]      m0_addr, m0_wdata;
  logic             m0_ack;
  logic [31:0]      m0_rdata;
  logic             m1_req, m1_we;
  logic [31:0]      m1_addr;
  logic [LEN_W-1:0] m1_len;
  logic [31:0]      m1_wdata;
  logic             m1_wnext, m1_rvalid, m1_done;
  logic [31:0]      m1_rdata;
  logic             mem_wr_n;
  logic [31:0]      mem_addr, mem_din, mem_dout;

  mem_arbiter #(.MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_len    (m1_len),
    .m1_wdata  (m1_wdata),
    .m1_wnext  (m1_wnext),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_done   (m1_done),
    .mem_wr_n  (mem_wr_n),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory: 256 bytes, address wraps modulo 256, big-endian words.
  logic [7:0] mem [256];
  logic [7:0] ma0, ma1, ma2, ma3;
  assign ma0 = mem_addr[7:0];
  assign ma1 = ma0 + 8'd1;
  assign ma2 = ma0 + 8'd2;
  assign ma3 = ma0 + 8'd3;
  assign mem_dout = {mem[ma0], mem[ma1], mem[ma2], mem[ma3]};

  always @(negedge clk) begin
    if (!mem_wr_n) begin
      mem[ma0] <= mem_din[31:24];
      mem[ma1] <= mem_din[23:16];
      mem[ma2] <= mem_din[15:8];
      mem[ma3] <= mem_din[7:0];
    end
  end

  // Reference model state.
  logic [7:0]  exp_mem [256];
  int          model_last;
  logic [31:0] m1_wd [32];
  logic [31:0] m1_rd_q [$];
  logic [31:0] m1_wa_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {exp_mem[b], exp_mem[8'(b + 8'd1)], exp_mem[8'(b + 8'd2)], exp_mem[8'(b + 8'd3)]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {mem[b], mem[8'(b + 8'd1)], mem[8'(b + 8'd2)], mem[8'(b + 8'd3)]};
  endfunction

  task automatic exp_write(input logic [31:0] a, input logic [31:0] w);
    logic [7:0] b;
    b = a[7:0];
    exp_mem[b]               = w[31:24];
    exp_mem[8'(b + 8'd1)]    = w[23:16];
    exp_mem[8'(b + 8'd2)]    = w[15:8];
    exp_mem[8'(b + 8'd3)]    = w[7:0];
  endtask

  function automatic int eff_len(input int len);
    if (len == 0) return 1;
    if (len > MAX_BURST) return MAX_BURST;
    return len;
  endfunction

  task automatic m0_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat);
    logic seen;
    seen  = 1'b0;
    lat   = -1;
    rdata = '0;
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (m0_ack) begin
        lat   = n - 1;
        rdata = m0_rdata;
        seen  = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    check("m0_ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic m1_burst(input logic we, input logic [31:0] base, input int len,
                          output int lat, output logic rv_at_done);
    logic seen;
    int   beat;
    seen       = 1'b0;
    beat       = 0;
    lat        = -1;
    rv_at_done = 1'b0;
    m1_rd_q.delete();
    m1_wa_q.delete();
    @(posedge clk); #1;
    m1_req = 1'b1; m1_we = we; m1_addr = base; m1_len = LEN_W'(len); m1_wdata = m1_wd[0];
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (m1_wnext) begin
        m1_wa_q.push_back(mem_addr);
        beat++;
      end
      if (m1_rvalid) m1_rd_q.push_back(m1_rdata);
      if (m1_done) begin
        lat        = n - 1;
        rv_at_done = m1_rvalid;
        seen       = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (beat < 32) m1_wdata = m1_wd[beat];
    end
    @(posedge clk); #1;
    m1_req = 1'b0;
    check("m1_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic model_m0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata);
    if (we) exp_write(addr, wdata);
    else    check("m0_rdata", rdata, exp_word(addr));
    model_last = 0;
  endtask

  task automatic model_m1(input logic we, input logic [31:0] base, input int len,
                          input logic rv_at_done);
    int l;
    l = eff_len(len);
    if (we) begin
      check("m1_wbeats", 32'(m1_wa_q.size()), 32'(l));
      for (int i = 0; i < l; i++) begin
        logic [31:0] a;
        a = base + 32'(4 * i);
        if (i < m1_wa_q.size()) check("m1_waddr", m1_wa_q[i], a);
        exp_write(a, m1_wd[i]);
      end
    end else begin
      check("m1_rbeats", 32'(m1_rd_q.size()), 32'(l));
      for (int i = 0; i < l; i++) begin
        logic [31:0] a;
        a = base + 32'(4 * i);
        if (i < m1_rd_q.size()) check("m1_rdata", m1_rd_q[i], exp_word(a));
      end
      check("m1_rvalid_at_done", 32'(rv_at_done), 32'd1);
    end
    model_last = 1;
  endtask

  task automatic m0_do(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    int          lat;
    m0_xfer(we, addr, wdata, rd, lat);
    check("m0_latency", 32'(lat), 32'd2);
    model_m0(we, addr, wdata, rd);
  endtask

  task automatic m1_do(input logic we, input logic [31:0] base, input int len);
    int   lat;
    logic rv;
    m1_burst(we, base, len, lat, rv);
    check("m1_latency", 32'(lat), 32'(eff_len(len) + 1));
    model_m1(we, base, len, rv);
  endtask

  task automatic do_tie(input logic we0, input logic [31:0] a0, input logic [31:0] w0,
                        input logic we1, input logic [31:0] b1, input int len);
    logic [31:0] rd0;
    int          lat0, lat1, l;
    logic        rv, m0_first;
    l = eff_len(len);
`ifdef MEM_ARB_RR_EN
    m0_first = (model_last != 0);
`else
    m0_first = 1'b1;
`endif
    fork
      m0_xfer(we0, a0, w0, rd0, lat0);
      m1_burst(we1, b1, len, lat1, rv);
    join
    if (m0_first) begin
      check("tie_m0_first_lat0", 32'(lat0), 32'd2);
      check("tie_m0_first_lat1", 32'(lat1), 32'(l + 3));
      model_m0(we0, a0, w0, rd0);
      model_m1(we1, b1, len, rv);
    end else begin
      check("tie_m1_first_lat1", 32'(lat1), 32'(l + 1));
      check("tie_m1_first_lat0", 32'(lat0), 32'(l + 3));
      model_m1(we1, b1, len, rv);
      model_m0(we0, a0, w0, rd0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m0_ack"},    32'(m0_ack),    32'd0);
    check({tag, "_m0_rdata"},  m0_rdata,       32'd0);
    check({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'd0);
    check({tag, "_m1_rdata"},  m1_rdata,       32'd0);
    check({tag, "_m1_done"},   32'(m1_done),   32'd0);
    check({tag, "_m1_wnext"},  32'(m1_wnext),  32'd0);
    check({tag, "_mem_wr_n"},  32'(mem_wr_n),  32'd1);
    check({tag, "_mem_addr"},  mem_addr,       32'd0);
    check({tag, "_mem_din"},   mem_din,        32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat0, lat1;
    logic        rv;

    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_len = '0; m1_wdata = '0;
    model_last = 1;
    for (int i = 0; i < 32; i++) m1_wd[i] = '0;
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Preload every word with a random pattern through port 0.
    for (int a = 0; a < 256; a += 4) m0_do(1'b1, 32'(a), $urandom);

    // Single write then read-back, big-endian byte order.
    m0_do(1'b1, 32'h10, 32'hDEADBEEF);
    check("be_bytes_10", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);
    m0_xfer(1'b0, 32'h10, 32'h0, rd, lat0);
    check("m0_read_lat", 32'(lat0), 32'd2);
    check("m0_read_deadbeef", rd, 32'hDEADBEEF);
    model_last = 0;

    // Read burst of words 1..4 at base 0.
    for (int i = 0; i < 4; i++) m0_do(1'b1, 32'(4 * i), 32'(i + 1));
    m1_burst(1'b0, 32'h0, 4, lat1, rv);
    check("b4_lat", 32'(lat1), 32'd5);
    check("b4_count", 32'(m1_rd_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < m1_rd_q.size()) check("b4_rdata", m1_rd_q[i], 32'(i + 1));
    check("b4_rv_at_done", 32'(rv), 32'd1);
    model_last = 1;

    // Two simultaneous requests back to back.
    do_tie(1'b0, 32'h20, 32'h0, 1'b0, 32'h30, 2);
    do_tie(1'b0, 32'h24, 32'h0, 1'b0, 32'h34, 3);

    // Port 0 arrives mid-way through a maximum-length burst.
    fork
      m1_burst(1'b0, 32'h80, MAX_BURST, lat1, rv);
      begin
        repeat (3) @(posedge clk);
        m0_xfer(1'b0, 32'h08, 32'h0, rd, lat0);
      end
    join
    check("mid_m1_lat", 32'(lat1), 32'(MAX_BURST + 1));
    check("mid_m0_lat", 32'(lat0), 32'(MAX_BURST));
    model_m1(1'b0, 32'h80, MAX_BURST, rv);
    model_m0(1'b0, 32'h08, 32'h0, rd);

    // Length 0 and address wrap at the top of the address space.
    m1_wd[0] = 32'hA5A5_0001;
    m1_wd[1] = 32'hA5A5_0002;
    m1_do(1'b1, 32'hFFFF_FFFC, 0);
    check("wrap0_addr", (m1_wa_q.size() > 0) ? m1_wa_q[0] : 32'hX, 32'hFFFF_FFFC);
    m1_do(1'b1, 32'hFFFF_FFFC, 2);
    check("wrap2_addr1", (m1_wa_q.size() > 1) ? m1_wa_q[1] : 32'hX, 32'h0000_0000);
    m1_do(1'b0, 32'h40, 31);

    // Randomised mix of singles, bursts and ties.
    for (int it = 0; it < 40; it++) begin
      int unsigned op;
      int          len;
      logic        we0, we1;
      logic [31:0] a0, w0, b1;
      op  = $urandom_range(0, 2);
      len = int'($urandom_range(0, 20));
      we0 = 1'($urandom);
      we1 = 1'($urandom);
      a0  = $urandom;
      w0  = $urandom;
      b1  = {$urandom_range(0, 3) == 0 ? 24'hFFFFFF : 24'($urandom), 6'($urandom), 2'b00};
      for (int i = 0; i < 32; i++) m1_wd[i] = $urandom;
      case (op)
        0: m0_do(we0, a0, w0);
        1: m1_do(we1, b1, len);
        default: do_tie(we0, a0, w0, we1, b1, len);
      endcase
    end

    for (int a = 0; a < 256; a += 4)
      check("mem_final", mem_word(32'(a)), exp_word(32'(a)));

    // Reset during beat 2 of an 8-beat write burst at 0x40.
    @(posedge clk); #1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_len = LEN_W'(8); m1_wdata = 32'h1122_3344;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    m1_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = 1;
    exp_write(32'h40, 32'h1122_3344);
    exp_write(32'h44, 32'h1122_3344);
    for (int a = 32'h40; a < 32'h60; a += 4)
      check("midrst_mem", mem_word(32'(a)), exp_word(32'(a)));
    m0_do(1'b0, 32'h48, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
